seven_seg_mux_driver: RTL and testbench
=======================================

# seven_seg_mux_driver

Parametrised multiplexed seven-segment display driver for the chess-clock front panel, successor to the fixed 8-digit driver. Scans `DIGITS` digits from a flattened segment bus and adds per-digit decimal points, PWM brightness control, per-digit blinking for the edit and flag indications, and frame-synchronous input snapshotting to prevent display tearing. It sits between the time-formatting / BCD-to-segment logic and the board's common-anode display pins.

## Interface
- `DIGITS`, 8: number of multiplexed digits, at least 2.
- `BRIGHT_W`, 4: brightness width; one digit slot is 2^BRIGHT_W CE ticks.
- `BLINK_FRAMES`, 64: full scan frames per blink half-period, at least 1.
- `CLK`  in  1: system clock; all logic on the rising edge.
- `CLR_N`  in  1: reset; one clock; reset is asynchronous and active-low.
- `CE`  in  1: scan tick enable; all counters advance only when CE=1.
- `seg_in`  in  7*DIGITS: active-low segment patterns {g..a}; digit k is `seg_in[7k+6:7k]`; digit 0 is the leftmost.
- `dp_in`  in  DIGITS: decimal point request per digit, active-high.
- `blink_mask`  in  DIGITS: digits subject to blinking.
- `blink_en`  in  1: global blink enable.
- `brightness`  in  BRIGHT_W: duty value; 0 = dark, 2^BRIGHT_W-1 = maximum.
- `seg_out`  out  7: active-low segments.
- `dp_out`  out  1: active-low decimal point.
- `seg_select`  out  DIGITS: active-low one-cold anode select.
- `frame_start`  out  1: one-CLK pulse when a new frame's snapshot is taken.

## Operation
- State:
  - `phase`: BRIGHT_W bits.
  - `digit`: 0..DIGITS-1.
  - `frame_cnt`: 0..BLINK_FRAMES-1.
  - `blink_ph`: 1 bit.
  - `seg_sh`, `dp_sh`: shadow registers.
- Advance on each CLK where CE=1:
  - `phase` increments.
  - When `phase` wraps from max to 0, `digit` increments.
  - When `digit` wraps from DIGITS-1 to 0, `frame_cnt` increments.
  - When `frame_cnt` wraps, `blink_ph` toggles.
- Snapshot:
  - On the CE tick that moves the state to digit=0, phase=0 (the frame wrap), `seg_sh` <= `seg_in` and `dp_sh` <= `dp_in`.
  - `frame_start` pulses on that same edge.
  - Input changes mid-frame never appear until the next frame.
- Lit condition: `1 <= phase <= brightness`, and not (`blink_en` & `blink_mask[digit]` & `blink_ph`).
  - Phase 0 is always dark. This is the anti-ghosting gap at each digit change.
- When lit:
  - `seg_select` = ~(1<<digit).
  - `seg_out` = `seg_sh[digit]`.
  - `dp_out` = ~`dp_sh[digit]`.
- When dark: `seg_select`, `seg_out` and `dp_out` are all ones.
- `brightness` and the blink controls are used live, not snapshotted.
- Duty = brightness / 2^BRIGHT_W of each slot.
- CE=0: all counters and outputs hold their values.
- `blink_en`=0: blanking is suppressed immediately; `blink_ph` keeps running.

## Timing
- All outputs are registered and reflect the counter state after the same edge: if the edge at cycle t advances `phase` to p, the outputs for p are valid after edge t+1 (1 CLK latency).
- Slot length is 2^BRIGHT_W CE ticks; frame length is DIGITS*2^BRIGHT_W CE ticks.
- Blink half-period is BLINK_FRAMES frames.
- Reset (CLR_N=0, asynchronous, takes effect immediately):
  - `phase`=0, `digit`=0, `frame_cnt`=0, `blink_ph`=0.
  - `seg_sh`=all ones, `dp_sh`=0.
  - `seg_out`=7'h7F, `dp_out`=1, `seg_select`=all ones, `frame_start`=0.
- After reset release:
  - The outputs stay dark until the first frame wrap loads the shadow registers.
  - The first `frame_start` occurs on CE tick DIGITS*2^BRIGHT_W.
- Reset asserted mid-frame: all outputs dark in the same cycle, with no glitch to a lit value.
- Brightness changed mid-slot: takes effect on the next edge's compare. No extra slot or skipped digit.

## Test plan
- Reset: hold CLR_N=0 and toggle CE.
  - Required: seg_out=7F, dp_out=1, seg_select=FF, frame_start=0 throughout.
  - Release reset, then require dark outputs for 128 CE ticks and a frame_start pulse on tick 128.
- Scan order (DIGITS=8, brightness=15, patterns 79,24,30,19,12,02,78,00 hex):
  - Required: seg_select cycles FE,FD,FB,…,7F, each for 15 lit ticks plus 1 dark tick.
  - Required: seg_out matches the selected digit's pattern.
- Brightness:
  - brightness=0: seg_select=FF at all times.
  - brightness=4: exactly 4 lit ticks per slot, at phases 1–4.
- Tearing: change `seg_in` digit 3 from 30 to 19 mid-frame.
  - Required: the old value (30) is shown until the next frame_start; 19 is shown from then on.
- Blink (BLINK_FRAMES=2, blink_mask=0x03, blink_en=1):
  - Required: digits 0–1 dark for 2 frames and lit for 2 frames, alternating.
  - Required: digits 2–7 unaffected.
  - Required: dp_out follows dp_in on the lit digits.
- CE hold and reset mid-scan:
  - CE=0 for 50 cycles: outputs frozen.
  - CLR_N pulsed low for 3 ns between edges: immediately dark, and counters back at digit 0, phase 0.

Source files
------------

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed common-anode seven-segment scanner with PWM dimming, per-digit blink and frame-synchronous input snapshot.
// Latency: outputs registered, 1 CLK behind the scan counters; CE=0 freezes counters and outputs.
module seven_seg_mux_driver #(
  parameter int DIGITS       = 8,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  input  logic                  CE,
  input  logic [7*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blink_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     seg_select,
  output logic                  frame_start
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BRIGHT_W-1:0]     phase;
  logic [DW-1:0]           digit;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_ph;
  logic                    loaded;
  logic [DIGITS-1:0][6:0]  seg_sh;
  logic [DIGITS-1:0]       dp_sh;

  logic slot_end;
  logic frame_end;
  logic blink_end;
  logic lit;

  always_comb begin
    slot_end  = &phase;
    frame_end = slot_end && (digit == DW'(DIGITS - 1));
    blink_end = frame_end && (frame_cnt == FW'(BLINK_FRAMES - 1));
    // Phase 0 stays dark so the anode change never overlaps old segments.
    lit = loaded && (phase != '0) && (phase <= brightness) &&
          !(blink_en && blink_mask[digit] && blink_ph);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      phase       <= '0;
      digit       <= '0;
      frame_cnt   <= '0;
      blink_ph    <= 1'b0;
      loaded      <= 1'b0;
      seg_sh      <= '1;
      dp_sh       <= '0;
      seg_out     <= 7'h7F;
      dp_out      <= 1'b1;
      seg_select  <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= CE && frame_end;
      if (CE) begin
        phase <= phase + 1'b1;
        if (slot_end) begin
          digit <= frame_end ? '0 : digit + 1'b1;
        end
        if (frame_end) begin
          frame_cnt <= blink_end ? '0 : frame_cnt + 1'b1;
          seg_sh    <= seg_in;
          dp_sh     <= dp_in;
          loaded    <= 1'b1;
        end
        if (blink_end) begin
          blink_ph <= ~blink_ph;
        end
        if (lit) begin
          seg_select <= ~(DIGITS'(1) << digit);
          seg_out    <= seg_sh[digit];
          dp_out     <= ~dp_sh[digit];
        end else begin
          seg_select <= '1;
          seg_out    <= 7'h7F;
          dp_out     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Bench for seven_seg_mux_driver: tick-indexed reference model feeding an expectation queue, plus reset vectors and hand-counted corner cases.
module tb_seven_seg_mux_driver;
  localparam int DIGITS = 8;
  localparam int BRIGHT_W = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT = 16;
  localparam int FRAME = DIGITS * SLOT;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic        CE;
  logic [55:0] seg_in;
  logic [7:0]  dp_in;
  logic [7:0]  blink_mask;
  logic        blink_en;
  logic [3:0]  brightness;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [7:0]  seg_select;
  logic        frame_start;

  seven_seg_mux_driver #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .seg_in(seg_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .blink_en(blink_en), .brightness(brightness),
    .seg_out(seg_out), .dp_out(dp_out), .seg_select(seg_select), .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  typedef struct {
    logic ce;
    out_t want;
  } vec_t;

  localparam out_t DARK = '{sel: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

  out_t        cur;
  out_t        exp_q[$];
  out_t        last_exp;
  int          t_ticks;
  logic [55:0] m_seg;
  logic [7:0]  m_dp;
  int          total = 0;
  int          bad = 0;
  int          lit_per[8];
  int          fs_count;
  logic [6:0]  last_d3;

  assign cur = {seg_select, seg_out, dp_out, frame_start};

  task automatic check(input string name, input out_t act, input out_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t T=%0d got sel=%h seg=%h dp=%b fs=%b want sel=%h seg=%h dp=%b fs=%b",
               name, $time, t_ticks, act.sel, act.seg, act.dp, act.fs,
               want.sel, want.seg, want.dp, want.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, want);
    end
  endtask

  // Expected registered outputs for the scan state reached t CE ticks after reset.
  function automatic out_t model_out(input int t);
    out_t o;
    int p, d, f;
    logic bph, lit;
    p = t % SLOT;
    d = (t / SLOT) % DIGITS;
    f = t / FRAME;
    bph = ((f / BLINK_FRAMES) % 2) == 1;
    lit = (t >= FRAME) && (p >= 1) && (p <= int'(brightness)) &&
          !(blink_en && blink_mask[d] && bph);
    o = DARK;
    if (lit) begin
      o.sel = ~(8'h01 << d);
      o.seg = m_seg[7*d +: 7];
      o.dp  = ~m_dp[d];
    end
    o.fs = ((t + 1) % FRAME) == 0;
    return o;
  endfunction

  task automatic model_reset();
    t_ticks  = 0;
    m_seg    = '1;
    m_dp     = '0;
    last_exp = DARK;
    exp_q.delete();
  endtask

  task automatic step(input logic ce);
    out_t e;
    CE = ce;
    if (ce) begin
      e = model_out(t_ticks);
    end else begin
      e = last_exp;
      e.fs = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge CLK);
    if (ce) begin
      t_ticks++;
      if (t_ticks % FRAME == 0) begin
        m_seg = seg_in;
        m_dp  = dp_in;
      end
    end
    last_exp = e;
    #1;
    check("scan", cur, exp_q.pop_front());
    for (int k = 0; k < 8; k++) if (cur.sel == ~(8'h01 << k)) lit_per[k]++;
    if (cur.fs) fs_count++;
    if (cur.sel == 8'hF7) last_d3 = cur.seg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 8; k++) lit_per[k] = 0;
    fs_count = 0;
  endtask

  initial begin
    vec_t rst_tbl[6];
    int first_fs;
    int f, want0;

    CLR_N = 1'b0;
    CE = 1'b0;
    seg_in = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    dp_in = 8'h05;
    blink_mask = 8'h00;
    blink_en = 1'b0;
    brightness = 4'd15;
    clear_counts();
    last_d3 = 7'h7F;

    for (int i = 0; i < 6; i++) begin
      rst_tbl[i].ce = i[0];
      rst_tbl[i].want = DARK;
    end
    for (int i = 0; i < 6; i++) begin
      CE = rst_tbl[i].ce;
      @(posedge CLK);
      #1;
      check("reset_hold", cur, rst_tbl[i].want);
    end

    // Release and find the first frame_start: expected on CE tick 128.
    CLR_N = 1'b1;
    model_reset();
    first_fs = -1;
    for (int i = 0; i < 200; i++) begin
      step(1'b1);
      if (cur.fs && first_fs < 0) first_fs = i + 1;
    end
    check_int("first_frame_start", first_fs, FRAME);
    while (t_ticks % FRAME != 0) step(1'b1);

    // Full-brightness scan: 15 lit ticks per digit.
    clear_counts();
    run(FRAME);
    for (int k = 0; k < 8; k++) check_int("scan_lit_b15", lit_per[k], 15);
    check_int("scan_fs_per_frame", fs_count, 1);

    brightness = 4'd4;
    clear_counts();
    run(FRAME);
    check_int("lit_b4_d0", lit_per[0], 4);
    check_int("lit_b4_d6", lit_per[6], 4);

    // Dark frame; digit 3 primed to 30 so the next snapshot captures it.
    brightness = 4'd0;
    seg_in[27:21] = 7'h30;
    clear_counts();
    run(FRAME);
    check_int("lit_b0_d0", lit_per[0], 0);
    check_int("lit_b0_d7", lit_per[7], 0);

    brightness = 4'd15;
    run(40);
    seg_in[27:21] = 7'h19;
    while (t_ticks % FRAME != 0) step(1'b1);
    check_int("tear_old", int'(last_d3), 'h30);
    run(FRAME);
    check_int("tear_new", int'(last_d3), 'h19);

    blink_en = 1'b1;
    blink_mask = 8'h03;
    for (int fr = 0; fr < 4; fr++) begin
      f = t_ticks / FRAME;
      want0 = ((f / BLINK_FRAMES) % 2 == 1) ? 0 : 15;
      clear_counts();
      run(FRAME);
      check_int("blink_d0", lit_per[0], want0);
      check_int("blink_d1", lit_per[1], want0);
      check_int("blink_d4", lit_per[4], 15);
    end

    // CE hold with a live-control change that must not leak through.
    blink_en = 1'b0;
    run(20);
    brightness = 4'd0;
    for (int i = 0; i < 50; i++) step(1'b0);
    brightness = 4'd15;
    run(5);

    @(posedge CLK);
    #3;
    CLR_N = 1'b0;
    #1;
    check("reset_async", cur, DARK);
    #2;
    CLR_N = 1'b1;
    model_reset();
    first_fs = -1;
    for (int i = 0; i < 140; i++) begin
      step(1'b1);
      if (cur.fs && first_fs < 0) first_fs = i + 1;
    end
    check_int("rst_mid_frame_start", first_fs, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
